sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in, parallel-out receiver: the receive end of the PISO serial link, MSB-first. Samples one bit per qualified clock, assembles WIDTH-bit words, and presents each completed word on a held parallel output with a valid/acknowledge handshake. It adds frame alignment through a sync strobe and flags overrun when the consumer falls behind. It sits between the serial line and the parallel consumer logic.

## Interface
- WIDTH, 4, word length in bits; legal range WIDTH ≥ 2
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- S_I  in  1  serial data, MSB of each word first
- S_V  in  1  bit-valid; S_I is sampled only in cycles where S_V=1
- S_SYNC  in  1  frame start; marks the current S_V bit as the MSB of a new word
- P_ACK  in  1  consumer acknowledge for the word on P_O
- P_O  out  WIDTH  last completed word, held until overwritten
- P_V  out  1  word valid, held until acknowledged
- BUSY  out  1  partial word in progress
- OVR  out  1  sticky overrun flag

## Operation
- Internal state: shift register sr[WIDTH-1:0] and bit counter cnt in 0..WIDTH-1.
- States: IDLE (cnt=0) and SHIFT (cnt≠0). BUSY = (cnt≠0), registered.
- S_V=1, S_SYNC=0: sr ← {sr[WIDTH-2:0], S_I}, cnt ← cnt+1.
- Word completion: S_V=1 with cnt=WIDTH-1 (or S_SYNC rule below). Then P_O ← {sr[WIDTH-2:0], S_I}, cnt ← 0, P_V ← 1.
- S_V=1, S_SYNC=1: the partial word is discarded; the bit is loaded as the first bit and cnt ← 1.
- S_SYNC=1, S_V=0: cnt ← 0 and the partial word is discarded. sr contents are don't-care.
- P_ACK=1 with P_V=1 and no completion this cycle: P_V ← 0. P_ACK with P_V=0 is ignored.
- Completion and P_ACK in the same cycle: the new word loads, P_V stays 1, OVR is unchanged.
- Completion while P_V=1 and P_ACK=0: P_O is overwritten, P_V stays 1, OVR ← 1.
- OVR is cleared only by rst.
- S_V=0: no state change except the P_ACK and S_SYNC effects above.

## Timing
- rst: P_O=0, P_V=0, BUSY=0, OVR=0, cnt=0, sr=0 after the reset edge. Reset mid-word discards the partial word and any pending P_V.
- rst has priority over all other inputs in the same cycle.
- Latency: P_O and P_V update on the edge that samples the last bit. They are visible in the cycle after the last S_V=1 cycle.
- Back-to-back words with S_V held high have zero gap: a completion occurs every WIDTH cycles.
- Pairing: a PISO transmitter shifting every clock (S_L=1) after a load of A drives A[3], A[2], A[1], A[0] in consecutive cycles. With S_V=1 and S_SYNC asserted on the A[3] cycle, P_O = A with WIDTH=4.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package sipo_pkg contains:
  - the default WIDTH constant
  - CNT_W = $clog2(WIDTH)
  - the state enum {IDLE, SHIFT}
- Sub-module sipo_bit_counter handles the counter logic:
  - ports: clk, rst, inc, clr_load
  - outputs: cnt and a last flag (cnt = WIDTH-1)
- The top level holds sr, P_O, P_V, OVR and the handshake logic.

## Test plan
1. rst, then S_V=1 for 4 cycles, S_SYNC=1 on the first, bits 1,0,1,1 → next cycle P_O=4'hB, P_V=1, BUSY=0, OVR=0.
2. S_V alternating 1,0 with bits 0,1,1,0 on the valid cycles → P_V stays 0 until the 4th valid bit, then P_O=4'h6.
3. Words 4'hB then 4'h5 back-to-back with no P_ACK → after the second completion P_O=4'h5, P_V=1, OVR=1. OVR persists after a later P_ACK; P_V then drops to 0.
4. P_ACK asserted on the same cycle as the second word's last bit → P_V stays 1, P_O=4'h5, OVR=0.
5. Bits 1,1, then S_SYNC with bits 1,1,0,0 → P_O=4'hC, exactly one P_V rise.
6. rst after 3 bits of a word (P_V=1 pending) → all outputs 0 next cycle. The following 4 bits 0,0,1,1 give P_O=4'h3.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and types for the sipo_rx serial receiver.
package sipo_pkg;
  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/sipo_rx_if.sv
// Serial-line and parallel-handshake bundle for sipo_rx.
interface sipo_rx_if import sipo_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             S_I;
  logic             S_V;
  logic             S_SYNC;
  logic             P_ACK;
  logic [WIDTH-1:0] P_O;
  logic             P_V;
  logic             BUSY;
  logic             OVR;

  modport master (
    output S_I, S_V, S_SYNC, P_ACK,
    input  P_O, P_V, BUSY, OVR
  );

  modport slave (
    input  S_I, S_V, S_SYNC, P_ACK,
    output P_O, P_V, BUSY, OVR
  );
endinterface

// File: rtl/sipo_bit_counter.sv
// Bit position counter for sipo_rx: wraps after WIDTH valid bits, reloads on sync.
module sipo_bit_counter import sipo_pkg::*; #(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr_load,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(WIDTH - 1));

  // A sync with a valid bit makes that bit the first of the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_load) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver, MSB first, with valid/ack handshake and sticky overrun.
module sipo_rx import sipo_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  sipo_rx_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             complete;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_next;

  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (bus.S_V),
    .clr_load (bus.S_SYNC),
    .cnt      (cnt),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.S_SYNC)     state_d = bus.S_V ? SHIFT : IDLE;
    else if (bus.S_V)   state_d = last ? IDLE : SHIFT;
    else                state_d = (cnt != '0) ? SHIFT : IDLE;
  end

  always_comb begin
    bus.BUSY = (state_q == SHIFT);
  end

  // Only the newest WIDTH-1 bits are kept; the incoming bit completes the word.
  assign sr_next  = {sr, bus.S_I};
  assign complete = bus.S_V && !bus.S_SYNC && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bus.P_O <= '0;
      bus.P_V <= 1'b0;
      bus.OVR <= 1'b0;
    end else begin
      if (bus.S_V) sr <= sr_next[WIDTH-2:0];
      if (complete) begin
        bus.P_O <= sr_next;
        bus.P_V <= 1'b1;
        if (bus.P_V && !bus.P_ACK) bus.OVR <= 1'b1;
      end else if (bus.P_ACK) begin
        bus.P_V <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed plus randomized bench for sipo_rx against a word-level reference model.
module tb_sipo_rx;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   pv_rises = 0;

  // Reference model state: bits collected so far, as a count and a number.
  int          m_cnt = 0;
  int unsigned m_acc = 0;
  int unsigned m_po  = 0;
  bit          m_pv  = 1'b0;
  bit          m_ovr = 1'b0;
  bit          prev_pv = 1'b0;

  sipo_rx_if #(.WIDTH(W)) bus ();

  sipo_rx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_update(input bit r, input bit sv, input bit si, input bit sy, input bit ak);
    bit done;
    done = 1'b0;
    if (r) begin
      m_cnt = 0; m_acc = 0; m_po = 0; m_pv = 1'b0; m_ovr = 1'b0;
    end else begin
      if (sy) begin
        m_cnt = sv ? 1 : 0;
        if (sv) m_acc = si;
      end else if (sv) begin
        m_acc = (m_acc * 2 + si) % (1 << W);
        m_cnt = m_cnt + 1;
        if (m_cnt == W) begin
          done  = 1'b1;
          m_cnt = 0;
        end
      end
      if (done) begin
        if (m_pv && !ak) m_ovr = 1'b1;
        m_po = m_acc;
        m_pv = 1'b1;
      end else if (ak) begin
        m_pv = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit sv, input bit si, input bit sy, input bit ak);
    @(negedge clk);
    rst        = r;
    bus.S_V    = sv;
    bus.S_I    = si;
    bus.S_SYNC = sy;
    bus.P_ACK  = ak;
    @(posedge clk);
    #1;
    model_update(r, sv, si, sy, ak);
    if (bus.P_V === 1'b1 && !prev_pv) pv_rises++;
    prev_pv = (bus.P_V === 1'b1);
    chk("model_p_o",  32'(bus.P_O),  32'(m_po));
    chk("model_p_v",  32'(bus.P_V),  32'(m_pv));
    chk("model_busy", 32'(bus.BUSY), 32'(m_cnt != 0));
    chk("model_ovr",  32'(bus.OVR),  32'(m_ovr));
  endtask

  // Sends one word MSB first, sync on its first bit, optional ack on its last bit.
  task automatic send_word(input logic [W-1:0] w, input bit ack_last);
    for (int unsigned i = 0; i < W; i++)
      step(1'b0, 1'b1, w[W-1-i], i == 0, ack_last && (i == W-1));
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] bits;
    bus.S_I = 1'b0; bus.S_V = 1'b0; bus.S_SYNC = 1'b0; bus.P_ACK = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_p_o", 32'(bus.P_O), 32'h0);
    chk("rst_p_v", 32'(bus.P_V), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_ovr", 32'(bus.OVR), 32'h0);

    // 1: basic word 1011
    send_word(4'hB, 1'b0);
    chk("t1_p_o", 32'(bus.P_O), 32'hB);
    chk("t1_p_v", 32'(bus.P_V), 32'h1);
    chk("t1_busy", 32'(bus.BUSY), 32'h0);
    chk("t1_ovr", 32'(bus.OVR), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_ack_p_v", 32'(bus.P_V), 32'h0);

    // 2: gapped valid bits 0,1,1,0
    bits = 4'b0110;
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, bits[3-i], 1'b0, 1'b0);
      if (i < 3) begin
        chk("t2_p_v_pending", 32'(bus.P_V), 32'h0);
        chk("t2_busy", 32'(bus.BUSY), 32'h1);
        idle_step();
        chk("t2_p_v_gap", 32'(bus.P_V), 32'h0);
      end
    end
    chk("t2_p_o", 32'(bus.P_O), 32'h6);
    chk("t2_p_v", 32'(bus.P_V), 32'h1);

    // 3: back-to-back words without ack -> overrun, sticky after ack
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'hB, 1'b0);
    send_word(4'h5, 1'b0);
    chk("t3_p_o", 32'(bus.P_O), 32'h5);
    chk("t3_p_v", 32'(bus.P_V), 32'h1);
    chk("t3_ovr", 32'(bus.OVR), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ack_p_v", 32'(bus.P_V), 32'h0);
    chk("t3_ack_ovr", 32'(bus.OVR), 32'h1);

    // 4: ack coincident with completion -> no overrun
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'hB, 1'b0);
    send_word(4'h5, 1'b1);
    chk("t4_p_o", 32'(bus.P_O), 32'h5);
    chk("t4_p_v", 32'(bus.P_V), 32'h1);
    chk("t4_ovr", 32'(bus.OVR), 32'h0);

    // 5: realignment by sync discards partial word
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pv_rises = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(4'hC, 1'b0);
    idle_step();
    chk("t5_p_o", 32'(bus.P_O), 32'hC);
    chk("t5_rises", 32'(pv_rises), 32'h1);

    // 6: reset mid-word with a pending word
    send_word(4'hA, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_p_o", 32'(bus.P_O), 32'h0);
    chk("t6_rst_p_v", 32'(bus.P_V), 32'h0);
    chk("t6_rst_busy", 32'(bus.BUSY), 32'h0);
    chk("t6_rst_ovr", 32'(bus.OVR), 32'h0);
    bits = 4'b0011;
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, bits[3-i], 1'b0, 1'b0);
    chk("t6_p_o", 32'(bus.P_O), 32'h3);
    chk("t6_p_v", 32'(bus.P_V), 32'h1);

    // Randomized traffic against the model
    for (int unsigned n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 70,
           1'($urandom),
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
